alu_issue_wb: RTL and testbench
===============================

# alu_issue_wb

Issue and writeback stage wrapped around `alu_top`. It accepts R-type (OP, opcode 0110011) instruction words through a valid/ready handshake and decodes them. It reads operands from an internal 32-entry register file and drives `RS1`/`RS2`/`Funct3`/`Funct7` into the ALU. Two cycles after issue it captures the ALU's `RD` and writes it back to the destination register.

## Interface
- `WIDTH`, 32, data width; must match the ALU.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `instr_valid`  in  1  instruction word is present.
- `instr_ready`  out  1  stage accepts the word this cycle.
- `instr`  in  32  RISC-V instruction word.
- `RS1`  out  WIDTH  to ALU: value of x[rs1]; registered.
- `RS2`  out  WIDTH  to ALU: value of x[rs2]; registered.
- `Funct3`  out  3  to ALU: `instr[14:12]`; registered.
- `Funct7`  out  1  to ALU: `instr[30]`; registered.
- `alu_rd`  in  WIDTH+1  from ALU `RD`; bits `[WIDTH-1:0]` are written back, bit `WIDTH` is ignored.
- `illegal`  out  1  one-cycle pulse: the accepted word was not OP.
- `retire_cnt`  out  32  count of completed writebacks; wraps.
- `dbg_we`  in  1  debug register write enable.
- `dbg_addr`  in  5  debug read/write address.
- `dbg_wdata`  in  WIDTH  debug write data.
- `dbg_rdata`  out  WIDTH  combinational read of x[`dbg_addr`]; x0 reads 0.

## Operation
- Handshake: a transfer occurs at an edge where `instr_valid && instr_ready`.
- `instr_ready` may depend combinationally on `instr`. Once asserted, `instr_valid` and `instr` hold until the transfer.
- Decode fields: rd = `[11:7]`, funct3 = `[14:12]`, rs1 = `[19:15]`, rs2 = `[24:20]`, funct7 bit = `[30]`.
- Non-OP opcode: the word is consumed. `illegal` = 1 for the next cycle. No issue, no writeback, ALU outputs hold.
- Pipeline registers: EX (valid, rd) and WB (valid, rd).
  - Accept of an OP word loads EX and the ALU output registers.
  - EX moves to WB on every edge.
  - In WB, the register file writes `alu_rd[WIDTH-1:0]` to x[rd] at the edge ending that cycle.
- x0 rules: reads return 0, writes to x0 are dropped, rd = 0 never creates a hazard. The writeback still counts toward `retire_cnt`.
- Hazard stall: `instr_ready` = 0 when EX is valid, EX.rd ≠ 0, and (rs1 == EX.rd or rs2 == EX.rd). This inserts exactly one bubble; EX is invalid on the next edge.
- Forwarding: when WB is valid, WB.rd ≠ 0 and the operand index equals WB.rd, the operand takes `alu_rd[WIDTH-1:0]` instead of the register file value.
- Bubbles: `RS1`/`RS2`/`Funct3`/`Funct7` hold their last values. The ALU recomputing on held operands is harmless because WB is invalid.
- Debug write: x[`dbg_addr`] ← `dbg_wdata` at the edge.
  - If a writeback targets the same register in the same cycle, the writeback wins.
  - Debug writes are not tracked by hazard logic.
  - A debug write to x0 is dropped.
- `retire_cnt`: +1 per WB-valid edge; wraps from 0xFFFFFFFF to 0.

## Timing
- Accept at edge k:
  - ALU inputs valid after edge k.
  - ALU `RD` valid after edge k+1.
  - Register written at edge k+2.
  - `retire_cnt` increments at edge k+2.
- Back-to-back independent instructions: one per cycle.
- Dependent on the immediately preceding instruction: one bubble, then it reads via forwarding.
- Dependent on the instruction two ahead: no stall (forwarded).
- Dependent on the instruction three or more ahead: read from the register file.
- Reset (rst = 0 at an edge) clears:
  - all registers x1–x31, EX and WB valid;
  - `RS1`, `RS2`, `Funct3`, `Funct7`, `illegal`, `retire_cnt` to 0.
- `instr_ready` = 0 while rst = 0.
- Reset mid-flight: in-flight writebacks are discarded.

## Structure
- Shared package `alu_pkg` holds:
  - `OPC_OP` = 7'b0110011;
  - funct3 encodings ADD..AND (0..7);
  - instruction field bit positions;
  - register-index width 5.
- Sub-module `alu_regfile`: 31×WIDTH flops, two combinational read ports plus a debug read port, one writeback write port plus a debug write port with writeback priority, synchronous active-low clear.
- The top level holds decode, hazard/forward logic, pipeline valids and the counter.

## Test plan
- Independent back-to-back issue:
  - stimulus: debug-write x1 = 5, x2 = 7; issue ADD x3,x1,x2 then XOR x4,x2,x1 on consecutive cycles;
  - required: `instr_ready` stays 1; x3 = 12, x4 = 2; `retire_cnt` = 2.
- Adjacent RAW stall:
  - stimulus: ADD x3,x1,x2 followed by ADD x5,x3,x1 (x1 = 5, x2 = 7);
  - required: exactly one cycle with `instr_ready` = 0; x5 = 17.
- Distance-2 RAW:
  - stimulus: ADD x3; an independent instruction; then OR x6,x3,x1;
  - required: no stall; the `RS1` seen by the ALU is 12.
- Illegal opcode:
  - stimulus: issue 0x00000013 (ADDI);
  - required: `illegal` pulses for one cycle; no ALU input change; `retire_cnt` unchanged.
- x0 destination:
  - stimulus: ADD x0,x1,x2, then OR x7,x0,x1;
  - required: `dbg_rdata`@0 = 0; x7 = 5; no stall; `retire_cnt` counts both.
- Reset mid-flight:
  - stimulus: accept ADD x3,x1,x2, then assert rst = 0 at the next edge;
  - required: x3 = 0; `retire_cnt` = 0; `RS1` = `RS2` = 0; `instr_ready` = 0 until rst = 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the issue/writeback stage and its
// register file.
//   OPC_OP          : major opcode of R-type register/register ALU words
//   funct3_e        : ALU operation selector encodings (ADD..AND = 0..7)
//   *_LSB / *_MSB   : instruction field bit positions
//   REG_IDX_W       : register index width (32 architectural registers)
package alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam int         REG_IDX_W = 5;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_BIT  = 30;

  typedef enum logic [2:0] {
    F3_ADD  = 3'd0,
    F3_SLL  = 3'd1,
    F3_SLT  = 3'd2,
    F3_SLTU = 3'd3,
    F3_XOR  = 3'd4,
    F3_SR   = 3'd5,
    F3_OR   = 3'd6,
    F3_AND  = 3'd7
  } funct3_e;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 31 x WIDTH flop register file (x1..x31); x0 is hard-wired 0.
//   clk, rst_ni             : clock, synchronous active-low clear
//   ra1_i/rd1_o, ra2_i/rd2_o: combinational operand read ports
//   dbg_addr_i/dbg_rdata_o  : combinational debug read port
//   wb_we_i/wb_addr_i/wb_data_i        : writeback write port
//   dbg_we_i/dbg_addr_i/dbg_wdata_i    : debug write port
// When both write ports target the same register, the writeback wins.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  reg_idx_t         ra1_i,
  output logic [WIDTH-1:0] rd1_o,
  input  reg_idx_t         ra2_i,
  output logic [WIDTH-1:0] rd2_o,
  input  logic             wb_we_i,
  input  reg_idx_t         wb_addr_i,
  input  logic [WIDTH-1:0] wb_data_i,
  input  logic             dbg_we_i,
  input  reg_idx_t         dbg_addr_i,
  input  logic [WIDTH-1:0] dbg_wdata_i,
  output logic [WIDTH-1:0] dbg_rdata_o
);

  logic [WIDTH-1:0] regs [32];

  // x0 has no storage; writes addressed to it fall through every g_reg match.
  assign regs[0] = '0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_reg
    logic [WIDTH-1:0] x_q;

    always_ff @(posedge clk) begin
      if (!rst_ni) begin
        x_q <= '0;
      end else if (wb_we_i && (wb_addr_i == REG_IDX_W'(gi))) begin
        x_q <= wb_data_i;
      end else if (dbg_we_i && (dbg_addr_i == REG_IDX_W'(gi))) begin
        x_q <= dbg_wdata_i;
      end
    end

    assign regs[gi] = x_q;
  end

  assign rd1_o       = regs[ra1_i];
  assign rd2_o       = regs[ra2_i];
  assign dbg_rdata_o = regs[dbg_addr_i];

endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issue and writeback stage around an external ALU.
//   clk, rst                 : clock, synchronous active-low reset
//   instr_valid/instr_ready/instr : instruction handshake (R-type words)
//   RS1, RS2, Funct3, Funct7 : registered operands/selectors to the ALU
//   alu_rd                   : ALU result, one cycle after its inputs
//   illegal                  : one-cycle pulse after a non-OP word is consumed
//   retire_cnt               : count of completed writebacks (wraps)
//   dbg_we/dbg_addr/dbg_wdata/dbg_rdata : debug register access
// Pipeline: accept -> EX (ALU computing) -> WB (result written at end of WB).
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [WIDTH-1:0] RS1,
  output logic [WIDTH-1:0] RS2,
  output logic [2:0]       Funct3,
  output logic             Funct7,
  input  logic [WIDTH:0]   alu_rd,
  output logic             illegal,
  output logic [31:0]      retire_cnt,
  input  logic             dbg_we,
  input  logic [4:0]       dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic [WIDTH-1:0] dbg_rdata
);

  logic [6:0] dec_opc;
  reg_idx_t   dec_rd, dec_rs1, dec_rs2;
  logic [2:0] dec_f3;
  logic       dec_f7;

  assign dec_opc = instr[OPC_MSB:OPC_LSB];
  assign dec_rd  = instr[RD_MSB:RD_LSB];
  assign dec_f3  = instr[F3_MSB:F3_LSB];
  assign dec_rs1 = instr[RS1_MSB:RS1_LSB];
  assign dec_rs2 = instr[RS2_MSB:RS2_LSB];
  assign dec_f7  = instr[F7_BIT];

  // Carry/extra ALU bit and the funct7 bits other than bit 30 carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{alu_rd[WIDTH], instr[31], instr[29:25]};

  logic             ex_valid_q, ex_valid_d, wb_valid_q, wb_valid_d;
  reg_idx_t         ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]       f3_q, f3_d;
  logic             f7_q, f7_d;
  logic             illegal_q, illegal_d;
  logic [31:0]      retire_q, retire_d;

  logic             hazard, accept, is_op, issue, fwd1, fwd2;
  logic [WIDTH-1:0] rf_rd1, rf_rd2, wb_data;

  // The producer in EX has no result yet; forwarding only covers WB.
  assign hazard = ex_valid_q && (ex_rd_q != '0) &&
                  ((dec_rs1 == ex_rd_q) || (dec_rs2 == ex_rd_q));

  assign instr_ready = rst && !hazard;
  assign accept      = instr_valid && instr_ready;
  assign is_op       = (dec_opc == OPC_OP);
  assign issue       = accept && is_op;

  assign wb_data = alu_rd[WIDTH-1:0];
  assign fwd1    = wb_valid_q && (wb_rd_q != '0) && (dec_rs1 == wb_rd_q);
  assign fwd2    = wb_valid_q && (wb_rd_q != '0) && (dec_rs2 == wb_rd_q);

  alu_regfile #(
    .WIDTH(WIDTH)
  ) u_regfile (
    .clk         (clk),
    .rst_ni      (rst),
    .ra1_i       (dec_rs1),
    .rd1_o       (rf_rd1),
    .ra2_i       (dec_rs2),
    .rd2_o       (rf_rd2),
    .wb_we_i     (wb_valid_q),
    .wb_addr_i   (wb_rd_q),
    .wb_data_i   (wb_data),
    .dbg_we_i    (dbg_we),
    .dbg_addr_i  (dbg_addr),
    .dbg_wdata_i (dbg_wdata),
    .dbg_rdata_o (dbg_rdata)
  );

  always_comb begin
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    f3_d       = f3_q;
    f7_d       = f7_q;
    ex_valid_d = issue;
    ex_rd_d    = ex_rd_q;
    wb_valid_d = ex_valid_q;
    wb_rd_d    = ex_rd_q;
    illegal_d  = accept && !is_op;
    retire_d   = wb_valid_q ? (retire_q + 32'd1) : retire_q;
    // Bubbles and illegal words leave the ALU inputs untouched.
    if (issue) begin
      rs1_d   = fwd1 ? wb_data : rf_rd1;
      rs2_d   = fwd2 ? wb_data : rf_rd2;
      f3_d    = dec_f3;
      f7_d    = dec_f7;
      ex_rd_d = dec_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rs1_q      <= '0;
      rs2_q      <= '0;
      f3_q       <= '0;
      f7_q       <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      illegal_q  <= 1'b0;
      retire_q   <= '0;
    end else begin
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      f3_q       <= f3_d;
      f7_q       <= f7_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      illegal_q  <= illegal_d;
      retire_q   <= retire_d;
    end
  end

  assign RS1        = rs1_q;
  assign RS2        = rs2_q;
  assign Funct3     = f3_q;
  assign Funct7     = f7_q;
  assign illegal    = illegal_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: directed bench for alu_issue_wb with a registered ALU model
// and an architectural register-file reference.  Expected ALU inputs are queued
// when a word is driven and compared once the stage accepts it.
module tb_alu_issue_wb;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [WIDTH-1:0] RS1, RS2;
  logic [2:0]       Funct3;
  logic             Funct7;
  logic [WIDTH:0]   alu_rd;
  logic             illegal;
  logic [31:0]      retire_cnt;
  logic             dbg_we;
  logic [4:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_wdata;
  logic [WIDTH-1:0] dbg_rdata;

  always #5 clk = ~clk;

  alu_issue_wb #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .RS1         (RS1),
    .RS2         (RS2),
    .Funct3      (Funct3),
    .Funct7      (Funct7),
    .alu_rd      (alu_rd),
    .illegal     (illegal),
    .retire_cnt  (retire_cnt),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_rdata   (dbg_rdata)
  );

  function automatic logic [WIDTH:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3, input logic f7);
    logic [WIDTH:0] r;
    case (f3)
      3'd0:    r = f7 ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      3'd1:    r = {1'b0, a << b[4:0]};
      3'd2:    r = {32'd0, ($signed(a) < $signed(b))};
      3'd3:    r = {32'd0, (a < b)};
      3'd4:    r = {1'b1, a ^ b};
      3'd5:    r = f7 ? {1'b0, 32'($signed(a) >>> b[4:0])} : {1'b0, a >> b[4:0]};
      3'd6:    r = {1'b1, a | b};
      default: r = {1'b0, a & b};
    endcase
    return r;
  endfunction

  // ALU stand-in: one register stage between its inputs and RD.
  always @(posedge clk) alu_rd <= alu_f(RS1, RS2, Funct3, Funct7);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] refx[32];
  int          exp_retire;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] rtype(input logic f7b, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {1'b0, f7b, 5'd0, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
    if (a != 5'd0) refx[a] = d;
  endtask

  task automatic chk_reg(input logic [4:0] a, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, {1'b0, dbg_rdata}, {1'b0, refx[a]});
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic issue(input logic [31:0] w, input string tag, output int stalls);
    exp_t           e;
    logic           ok;
    logic           isop;
    logic [31:0]    pa, pb;
    logic [2:0]     pf3;
    logic           pf7;
    logic [WIDTH:0] res;
    isop = (w[6:0] == OPC_OP);
    if (isop) begin
      e.a = refx[w[19:15]]; e.b = refx[w[24:20]];
      e.f3 = w[14:12]; e.f7 = w[30]; e.rd = w[11:7];
      sb_q.push_back(e);
    end
    pa = RS1; pb = RS2; pf3 = Funct3; pf7 = Funct7;
    instr = w; instr_valid = 1'b1; stalls = 0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (instr_ready) ok = 1'b1; else stalls++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    chk({tag, " accept"}, {32'd0, ok}, 33'd1);
    $display("issue %s word=%08h stalls=%0d", tag, w, stalls);
    if (isop) begin
      e = sb_q.pop_front();
      chk({tag, " RS1"}, {1'b0, RS1}, {1'b0, e.a});
      chk({tag, " RS2"}, {1'b0, RS2}, {1'b0, e.b});
      chk({tag, " Funct3"}, {30'd0, Funct3}, {30'd0, e.f3});
      chk({tag, " Funct7"}, {32'd0, Funct7}, {32'd0, e.f7});
      res = alu_f(e.a, e.b, e.f3, e.f7);
      if (e.rd != 5'd0) refx[e.rd] = res[31:0];
      exp_retire++;
    end else begin
      chk({tag, " illegal"}, {32'd0, illegal}, 33'd1);
      chk({tag, " RS1 hold"}, {1'b0, RS1}, {1'b0, pa});
      chk({tag, " RS2 hold"}, {1'b0, RS2}, {1'b0, pb});
      chk({tag, " Funct3 hold"}, {30'd0, Funct3}, {30'd0, pf3});
      chk({tag, " Funct7 hold"}, {32'd0, Funct7}, {32'd0, pf7});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, s3;
    for (int i = 0; i < 32; i++) refx[i] = 32'd0;
    exp_retire = 0;
    rst = 1'b0; instr_valid = 1'b0; instr = 32'd0;
    dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset RS1", {1'b0, RS1}, 33'd0);
    chk("reset RS2", {1'b0, RS2}, 33'd0);
    chk("reset Funct3", {30'd0, Funct3}, 33'd0);
    chk("reset Funct7", {32'd0, Funct7}, 33'd0);
    chk("reset illegal", {32'd0, illegal}, 33'd0);
    chk("reset retire_cnt", {1'b0, retire_cnt}, 33'd0);
    chk("reset instr_ready", {32'd0, instr_ready}, 33'd0);
    chk_reg(5'd5, "reset x5");
    rst = 1'b1;

    dbg_write(5'd1, 32'd5);
    dbg_write(5'd2, 32'd7);
    dbg_write(5'd0, 32'hDEAD_BEEF);
    chk_reg(5'd0, "dbg x0 dropped");
    chk_reg(5'd1, "dbg x1");

    // Independent back-to-back issue.
    issue(rtype(1'b0, 5'd2, 5'd1, 3'd0, 5'd3), "ADD x3,x1,x2", s1);
    issue(rtype(1'b0, 5'd1, 5'd2, 3'd4, 5'd4), "XOR x4,x2,x1", s2);
    chk("b2b stalls", 33'(s1 + s2), 33'd0);
    drain();
    chk_reg(5'd3, "b2b x3");
    chk("b2b x3 literal", {1'b0, dbg_rdata}, 33'd12);
    chk_reg(5'd4, "b2b x4");
    chk("b2b x4 literal", {1'b0, dbg_rdata}, 33'd2);
    chk("b2b retire_cnt", {1'b0, retire_cnt}, 33'd2);

    // Adjacent RAW: one bubble then forwarding.
    dbg_write(5'd3, 32'd99);
    issue(rtype(1'b0, 5'd2, 5'd1, 3'd0, 5'd3), "ADD x3,x1,x2", s1);
    issue(rtype(1'b0, 5'd1, 5'd3, 3'd0, 5'd5), "ADD x5,x3,x1", s2);
    chk("raw1 stall count", 33'(s2), 33'd1);
    drain();
    chk_reg(5'd5, "raw1 x5");
    chk("raw1 x5 literal", {1'b0, dbg_rdata}, 33'd17);

    // Distance-2 RAW: no stall, forwarded operand.
    dbg_write(5'd3, 32'd99);
    issue(rtype(1'b0, 5'd2, 5'd1, 3'd0, 5'd3), "ADD x3,x1,x2", s1);
    issue(rtype(1'b0, 5'd2, 5'd1, 3'd7, 5'd8), "AND x8,x1,x2", s2);
    issue(rtype(1'b0, 5'd1, 5'd3, 3'd6, 5'd6), "OR x6,x3,x1", s3);
    chk("raw2 stalls", 33'(s2 + s3), 33'd0);
    chk("raw2 RS1 literal", {1'b0, RS1}, 33'd12);
    // Distance-3 read from the register file, plus SUB.
    issue(rtype(1'b1, 5'd2, 5'd3, 3'd0, 5'd9), "SUB x9,x3,x2", s1);
    drain();
    chk_reg(5'd6, "raw2 x6");
    chk_reg(5'd8, "raw2 x8");
    chk_reg(5'd9, "dist3 x9");
    chk("dist3 retire_cnt", {1'b0, retire_cnt}, 33'(exp_retire));

    // Illegal opcode.
    issue(32'h0000_0013, "ADDI (illegal)", s1);
    @(posedge clk); #1;
    chk("illegal pulse end", {32'd0, illegal}, 33'd0);
    drain();
    chk("illegal retire_cnt", {1'b0, retire_cnt}, 33'(exp_retire));

    // x0 destination.
    issue(rtype(1'b0, 5'd2, 5'd1, 3'd0, 5'd0), "ADD x0,x1,x2", s1);
    issue(rtype(1'b0, 5'd1, 5'd0, 3'd6, 5'd7), "OR x7,x0,x1", s2);
    chk("x0 stalls", 33'(s1 + s2), 33'd0);
    drain();
    chk_reg(5'd0, "x0 read");
    chk_reg(5'd7, "x0 x7");
    chk("x0 x7 literal", {1'b0, dbg_rdata}, 33'd5);
    chk("x0 retire_cnt", {1'b0, retire_cnt}, 33'(exp_retire));

    // Reset mid-flight.
    issue(rtype(1'b0, 5'd2, 5'd1, 3'd0, 5'd3), "ADD x3,x1,x2", s1);
    rst = 1'b0;
    instr = rtype(1'b0, 5'd2, 5'd1, 3'd0, 5'd9);
    instr_valid = 1'b1;
    @(negedge clk);
    chk("rst ready low 1", {32'd0, instr_ready}, 33'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst ready low 2", {32'd0, instr_ready}, 33'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) refx[i] = 32'd0;
    exp_retire = 0;
    chk("rst RS1", {1'b0, RS1}, 33'd0);
    chk("rst RS2", {1'b0, RS2}, 33'd0);
    chk("rst retire_cnt", {1'b0, retire_cnt}, 33'd0);
    chk_reg(5'd3, "rst x3");
    chk_reg(5'd1, "rst x1");
    instr_valid = 1'b0;
    rst = 1'b1;
    drain();
    chk("rst retire after", {1'b0, retire_cnt}, 33'd0);
    chk_reg(5'd3, "rst x3 after");
    chk("rst ready released", {32'd0, instr_ready}, 33'd1);
    chk("scoreboard empty", 33'(sb_q.size()), 33'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
